link_receiver: RTL and testbench
================================

LINK_RECEIVER -- requirements
Module: link_receiver

Interface
REQ-001 Parameter ENC, default "TP": link encoding, "TP" (two-phase, transition signalling) or "FP" (four-phase, return-to-zero).
REQ-002 Parameter WIDTH, default 1: data bits per link word.
REQ-003 Parameter DEPTH, default 4: output FIFO entries, power of two, >= 2.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer flops per rail, >= 2.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 in  input  [WIDTH-1:0][1:0]  dual-rail link from upstream link driver; [b][1] = true rail, [b][0] = false rail.
REQ-008 ack_o  output  1  link acknowledge to the upstream driver.
REQ-009 data_o  output  WIDTH  FIFO head word.
REQ-010 valid_o  output  1  FIFO non-empty.
REQ-011 ready_i  input  1  consumer accepts data_o.
REQ-012 err_o  output  1  sticky illegal-code flag.

Function
REQ-013 Every rail of in SHALL pass through a SYNC_STAGES-deep flop chain before any use; all logic SHALL use only the synchronized rails (sync).
REQ-014 TP: a reference register ref[WIDTH-1:0][1:0] SHALL hold the rail values of the last accepted word; bit b is complete when exactly one of its rails differs from ref[b].
REQ-015 TP: word complete when every bit is complete; captured data bit b = (sync[b][1] != ref[b][1]).
REQ-016 TP: on a clock edge where the word is complete and the FIFO is not full, the word SHALL be pushed, ref SHALL load sync, and ack_o SHALL toggle, all at that edge.
REQ-017 TP: a bit with both rails differing from ref SHALL set err_o; the word SHALL NOT be pushed and ack_o SHALL NOT change.
REQ-018 FP: state machine with states IDLE and WAIT_NULL; reset state IDLE.
REQ-019 FP IDLE: word complete when every bit has exactly one rail at 1; data bit b = sync[b][1]; on complete with FIFO not full, push, ack_o <= 1, go to WAIT_NULL.
REQ-020 FP WAIT_NULL: when all rails are 0, ack_o <= 0 and go to IDLE; otherwise hold.
REQ-021 FP: any bit with both rails at 1, in either state, SHALL set err_o; no push and no state change on that edge.
REQ-022 A partially arrived word (some bits incomplete) SHALL be ignored until complete; rail skew is tolerated without error.
REQ-023 FIFO full with a complete word: SHALL hold without push and without ack change; capture occurs on the first edge after a pop frees an entry.
REQ-024 Fullness SHALL be judged on the registered count; a pop and a blocked push in the same cycle SHALL NOT pass data through.
REQ-025 Pop SHALL occur when valid_o && ready_i; push and pop SHALL be allowed in the same cycle when not full.
REQ-026 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits.
REQ-027 data_o SHALL equal the head entry whenever valid_o = 1; data_o is don't-care when valid_o = 0.
REQ-028 Latency: an input transition SHALL cause a push SYNC_STAGES+1 edges later if the FIFO is not full, and valid_o SHALL be 1 after that edge.
REQ-029 err_o, once 1, SHALL stay 1 until reset.

Reset
REQ-030 While rst = 0, SHALL hold: synchronizers = 0, ref = 0, state = IDLE, ack_o = 0, valid_o = 0, err_o = 0, FIFO empty, pointers = 0.
REQ-031 Reset SHALL take effect asynchronously, mid-word included; the partial word SHALL be discarded; release SHALL be effective at the next edge.
REQ-032 The upstream link SHALL be reset concurrently so that its rails and ack phase both restart at 0.

Verification
REQ-033 TP, WIDTH=4, SYNC_STAGES=2: send 4'hA -> after 3 edges data_o = 4'hA, valid_o = 1, ack_o toggles 0->1; send 4'h5 -> ack_o toggles 1->0.
REQ-034 FP, WIDTH=4: send 4'h3, then null -> ack_o rises at capture and falls after the null is seen; data_o = 4'h3; state returns to IDLE.
REQ-035 DEPTH=4, ready_i = 0: send 5 words -> first 4 acked; the 5th is held with ack unchanged; one pop -> the 5th is captured on the next edge; order is preserved across pointer wrap.
REQ-036 Skew: rails of bit 3 arrive 5 cycles after bits 0-2 -> no push until bit 3 arrives; err_o = 0.
REQ-037 Illegal code: FP in[1] = 2'b11 -> err_o = 1 persistently, no push; TP both rails of one bit toggled -> err_o = 1, ack_o unchanged.
REQ-038 Reset asserted mid-FIFO (count = 2, FP in WAIT_NULL) -> valid_o = 0, ack_o = 0 immediately; after release, a new word is received correctly.

Source files
------------

// File: rtl/link_receiver.sv
// link_receiver: dual-rail delay-insensitive link receiver (TP or FP encoding)
// with per-rail synchronizers, link acknowledge and an output FIFO.
// Ports: clk; rst (async, active-low); in[b][1:0] dual-rail word (1=true,
// 0=false rail); ack_o link acknowledge; data_o/valid_o/ready_i FIFO read
// side; err_o sticky illegal-code flag.
module link_receiver #(
    parameter     ENC         = "TP",
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0][1:0] in,
    output logic                  ack_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  err_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Rail synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
    logic [WIDTH-1:0][1:0]                  sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Front end <-> FIFO signals
    // ------------------------------------------------------------------
    logic             push;
    logic [WIDTH-1:0] cap_data;
    logic             err_set;
    logic             ack_q;
    logic             full;

    // ------------------------------------------------------------------
    // Link decoder
    // ------------------------------------------------------------------
    if (ENC == "FP") begin : g_fp
        localparam logic IDLE      = 1'b0;
        localparam logic WAIT_NULL = 1'b1;

        logic             state_q;
        logic             state_d;
        logic             ack_d;
        logic [WIDTH-1:0] one_hot;
        logic [WIDTH-1:0] both;
        logic [WIDTH-1:0] data_v;
        logic             all_done;
        logic             any_bad;
        logic             all_null;

        always_comb begin
            one_hot = '0;
            both    = '0;
            data_v  = '0;
            for (int b = 0; b < WIDTH; b++) begin
                one_hot[b] = sync[b][1] ^ sync[b][0];
                both[b]    = sync[b][1] & sync[b][0];
                data_v[b]  = sync[b][1];
            end
        end

        assign all_done = &one_hot;
        assign any_bad  = |both;
        assign all_null = (sync == '0);
        assign cap_data = data_v;
        assign err_set  = any_bad;

        // State register
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next-state logic; an illegal code freezes the state
        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE: begin
                    if (!any_bad && all_done && !full) begin
                        state_d = WAIT_NULL;
                    end
                end
                WAIT_NULL: begin
                    if (!any_bad && all_null) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Output logic
        always_comb begin
            push  = 1'b0;
            ack_d = ack_q;
            case (state_q)
                IDLE: begin
                    if (!any_bad && all_done && !full) begin
                        push  = 1'b1;
                        ack_d = 1'b1;
                    end
                end
                WAIT_NULL: begin
                    if (!any_bad && all_null) begin
                        ack_d = 1'b0;
                    end
                end
                default: begin
                    push  = 1'b0;
                    ack_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ack_q <= 1'b0;
            end else begin
                ack_q <= ack_d;
            end
        end
    end else begin : g_tp
        logic [WIDTH-1:0][1:0] ref_q;
        logic [WIDTH-1:0][1:0] diff;
        logic [WIDTH-1:0]      one_hot;
        logic [WIDTH-1:0]      both;
        logic [WIDTH-1:0]      data_v;
        logic                  all_done;

        // A rail that differs from the last accepted word carries a transition
        assign diff = sync ^ ref_q;

        always_comb begin
            one_hot = '0;
            both    = '0;
            data_v  = '0;
            for (int b = 0; b < WIDTH; b++) begin
                one_hot[b] = diff[b][1] ^ diff[b][0];
                both[b]    = diff[b][1] & diff[b][0];
                data_v[b]  = diff[b][1];
            end
        end

        // Every bit one-hot implies no bit has both rails toggled
        assign all_done = &one_hot;
        assign push     = all_done && !full;
        assign cap_data = data_v;
        assign err_set  = |both;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ref_q <= '0;
                ack_q <= 1'b0;
            end else if (push) begin
                ref_q <= sync;
                ack_q <= ~ack_q;
            end
        end
    end

    assign ack_o = ack_q;

    // ------------------------------------------------------------------
    // Sticky error
    // ------------------------------------------------------------------
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             pop;

    // Full is taken from the registered count so a same-cycle pop never
    // lets a blocked word slip through.
    assign full    = (count == CNT_FULL);
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_link_receiver.sv
// tb_link_receiver: directed bench for link_receiver, one TP and one FP
// instance (WIDTH=4, DEPTH=4, SYNC_STAGES=2) with a word scoreboard each.
module tb_link_receiver;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [3:0][1:0] tin;
    logic [3:0][1:0] fin;

    logic       tp_ack, tp_valid, tp_err, tp_rdy;
    logic [3:0] tp_data;
    logic       fp_ack, fp_valid, fp_err, fp_rdy;
    logic [3:0] fp_data;

    int checks = 0;
    int errors = 0;

    logic [3:0] tp_q[$];
    logic [3:0] fp_q[$];
    logic       exp_tp_ack;

    always #5 clk = ~clk;

    link_receiver #(
        .ENC("TP"), .WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)
    ) u_tp (
        .clk(clk), .rst(rst), .in(tin), .ack_o(tp_ack),
        .data_o(tp_data), .valid_o(tp_valid), .ready_i(tp_rdy),
        .err_o(tp_err)
    );

    link_receiver #(
        .ENC("FP"), .WIDTH(4), .DEPTH(4), .SYNC_STAGES(2)
    ) u_fp (
        .clk(clk), .rst(rst), .in(fin), .ack_o(fp_ack),
        .data_o(fp_data), .valid_o(fp_valid), .ready_i(fp_rdy),
        .err_o(fp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggle one rail per masked bit: rail 1 for a 1, rail 0 for a 0
    task automatic tp_send(input logic [3:0] w, input logic [3:0] m);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) tin[b][w[b]] = ~tin[b][w[b]];
        end
    endtask

    task automatic fp_send(input logic [3:0] w);
        for (int b = 0; b < 4; b++) begin
            fin[b] = w[b] ? 2'b10 : 2'b01;
        end
    endtask

    task automatic tp_pop(input string tag);
        logic [3:0] e = 'x;
        if (tp_q.size() > 0) e = tp_q.pop_front();
        chk({tag, "_valid"}, tp_valid, 1);
        chk({tag, "_data"}, tp_data, e);
        tp_rdy = 1'b1;
        step(1);
        tp_rdy = 1'b0;
    endtask

    task automatic fp_pop(input string tag);
        logic [3:0] e = 'x;
        if (fp_q.size() > 0) e = fp_q.pop_front();
        chk({tag, "_valid"}, fp_valid, 1);
        chk({tag, "_data"}, fp_data, e);
        fp_rdy = 1'b1;
        step(1);
        fp_rdy = 1'b0;
    endtask

    initial begin
        logic [3:0] w;
        tin = '0;
        fin = '0;
        tp_rdy = 1'b0;
        fp_rdy = 1'b0;
        exp_tp_ack = 1'b0;

        // Reset state
        step(3);
        chk("rst_tp_ack", tp_ack, 0);
        chk("rst_tp_valid", tp_valid, 0);
        chk("rst_tp_err", tp_err, 0);
        chk("rst_fp_ack", fp_ack, 0);
        chk("rst_fp_valid", fp_valid, 0);
        chk("rst_fp_err", fp_err, 0);
        rst = 1'b1;

        // TP basic: latency of three edges, ack toggles per word
        tp_send(4'hA, 4'hF);
        tp_q.push_back(4'hA);
        step(2);
        chk("tp_lat_valid", tp_valid, 0);
        chk("tp_lat_ack", tp_ack, 0);
        step(1);
        exp_tp_ack = 1'b1;
        chk("tp_a_valid", tp_valid, 1);
        chk("tp_a_ack", tp_ack, exp_tp_ack);
        tp_pop("tp_a");
        tp_send(4'h5, 4'hF);
        tp_q.push_back(4'h5);
        step(3);
        exp_tp_ack = 1'b0;
        chk("tp_5_ack", tp_ack, exp_tp_ack);
        tp_pop("tp_5");

        // FP basic: ack rises on capture, falls after null
        fp_send(4'h3);
        fp_q.push_back(4'h3);
        step(3);
        chk("fp_3_ack_hi", fp_ack, 1);
        chk("fp_3_valid", fp_valid, 1);
        fin = '0;
        step(2);
        chk("fp_null_ack_hold", fp_ack, 1);
        step(1);
        chk("fp_null_ack_lo", fp_ack, 0);
        fp_pop("fp_3");
        fp_send(4'h6);
        fp_q.push_back(4'h6);
        step(3);
        chk("fp_6_ack_hi", fp_ack, 1);
        fin = '0;
        step(3);
        chk("fp_6_ack_lo", fp_ack, 0);
        fp_pop("fp_6");

        // TP FIFO full, hold, pop-then-capture, order across wrap
        for (int i = 0; i < 5; i++) begin
            w = 4'(4'h1 + 4'(i) * 4'h3);
            tp_send(w, 4'hF);
            tp_q.push_back(w);
            step(3);
            if (i < 4) exp_tp_ack = ~exp_tp_ack;
            chk($sformatf("tp_full_ack%0d", i), tp_ack, exp_tp_ack);
        end
        step(2);
        chk("tp_full_hold_ack", tp_ack, exp_tp_ack);
        tp_pop("tp_full_p0");
        chk("tp_full_popedge_ack", tp_ack, exp_tp_ack);
        step(1);
        exp_tp_ack = ~exp_tp_ack;
        chk("tp_full_capture_ack", tp_ack, exp_tp_ack);
        for (int i = 1; i < 5; i++) begin
            tp_pop($sformatf("tp_full_p%0d", i));
        end
        chk("tp_drained_valid", tp_valid, 0);

        // TP skew: bit 3 arrives five cycles late
        tp_send(4'h9, 4'b0111);
        step(5);
        chk("tp_skew_valid", tp_valid, 0);
        chk("tp_skew_ack", tp_ack, exp_tp_ack);
        chk("tp_skew_err", tp_err, 0);
        tp_send(4'h9, 4'b1000);
        tp_q.push_back(4'h9);
        step(3);
        exp_tp_ack = ~exp_tp_ack;
        chk("tp_skew_done_ack", tp_ack, exp_tp_ack);
        chk("tp_skew_done_err", tp_err, 0);
        tp_pop("tp_skew");

        // FP reset mid-FIFO with link in WAIT_NULL
        fp_send(4'h1);
        step(3);
        fin = '0;
        step(3);
        fp_send(4'h2);
        step(3);
        chk("fp_pre_rst_ack", fp_ack, 1);
        chk("fp_pre_rst_valid", fp_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("fp_rst_valid", fp_valid, 0);
        chk("fp_rst_ack", fp_ack, 0);
        chk("tp_rst_valid", tp_valid, 0);
        chk("tp_rst_ack", tp_ack, 0);
        tin = '0;
        fin = '0;
        exp_tp_ack = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        fp_send(4'hC);
        fp_q.push_back(4'hC);
        step(3);
        chk("fp_post_rst_ack", fp_ack, 1);
        chk("fp_post_rst_err", fp_err, 0);
        fp_pop("fp_post_rst");
        fin = '0;
        step(3);
        chk("fp_post_null_ack", fp_ack, 0);

        // Illegal codes
        fin = {2'b01, 2'b01, 2'b11, 2'b01};
        step(3);
        chk("fp_bad_err", fp_err, 1);
        chk("fp_bad_valid", fp_valid, 0);
        chk("fp_bad_ack", fp_ack, 0);
        fin = '0;
        step(4);
        chk("fp_bad_err_sticky", fp_err, 1);
        chk("fp_bad_valid_later", fp_valid, 0);
        tin[0] = 2'b11;
        step(3);
        chk("tp_bad_err", tp_err, 1);
        chk("tp_bad_ack", tp_ack, exp_tp_ack);
        chk("tp_bad_valid", tp_valid, 0);

        chk("tp_sb_empty", tp_q.size(), 0);
        chk("fp_sb_empty", fp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
